// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int CNT_W = 8;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester-side beat streams plus the downstream FIFO write port, bundled for the arbiter.
interface fifo_wr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32
);

  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*DWIDTH-1:0] req_data_i;
  logic [NREQ-1:0]        req_last_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   fifo_wr_o;
  logic [DWIDTH-1:0]      fifo_data_o;
  logic                   fifo_full_i;
  logic [NREQ-1:0]        grant_o;
  logic [IDW-1:0]         grant_id_o;
  logic                   busy_o;

  // The arbiter owns the FIFO write port, so it is the master side.
  modport master (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, fifo_wr_o, fifo_data_o, grant_o, grant_id_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, fifo_wr_o, fifo_data_o, grant_o, grant_id_o, busy_o
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the last winner, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_lastWinner,
  output logic            o_anyValid,
  output logic [IDW-1:0]  o_pick
);

  // Wrapped candidates (at or below the last winner) are overridden by any candidate above it.
  always_comb begin
    o_anyValid = |i_req;
    o_pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k] && (k <= int'(i_lastWinner))) o_pick = IDW'(k);
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k] && (k > int'(i_lastWinner))) o_pick = IDW'(k);
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FWFT FIFO write port among NREQ requesters,
// holding each grant for one packet or at most MAXBURST beats.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 32,
  parameter int MAXBURST = 16
) (
  input logic         clk,
  input logic         rst,
  fifo_wr_arb_if.master bus
);

  localparam int IDW = idw(NREQ);

  arb_state_t       r_state, w_stateNext;
  logic [NREQ-1:0]  r_grant, w_grantNext;
  logic [IDW-1:0]   r_grantId, w_grantIdNext;
  logic [IDW-1:0]   r_lastWinner, w_lastWinnerNext;
  logic [CNT_W-1:0] r_count, w_countNext, w_countInc;
  logic [IDW-1:0]   w_pick;
  logic             w_anyValid, w_beat, w_release;
  logic [DWIDTH-1:0] w_grantData;
  logic             w_grantValid, w_grantLast;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req        (bus.req_valid_i),
    .i_lastWinner (r_lastWinner),
    .o_anyValid   (w_anyValid),
    .o_pick       (w_pick)
  );

  always_comb begin
    w_grantData  = '0;
    w_grantValid = 1'b0;
    w_grantLast  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grantId == IDW'(k)) begin
        w_grantData  = bus.req_data_i[k*DWIDTH +: DWIDTH];
        w_grantValid = bus.req_valid_i[k];
        w_grantLast  = bus.req_last_i[k];
      end
    end
  end

  always_comb begin
    w_beat           = (r_state == XFER) && !bus.fifo_full_i && w_grantValid;
    w_countInc       = (r_count == '1) ? r_count : r_count + 1'b1;
    w_release        = w_beat && (w_grantLast || (int'(w_countInc) >= MAXBURST));
    w_stateNext      = r_state;
    w_grantNext      = r_grant;
    w_grantIdNext    = r_grantId;
    w_lastWinnerNext = r_lastWinner;
    w_countNext      = r_count;
    case (r_state)
      IDLE: begin
        if (w_anyValid) begin
          w_stateNext      = XFER;
          w_grantNext      = NREQ'(1) << w_pick;
          w_grantIdNext    = w_pick;
          w_lastWinnerNext = w_pick;
          w_countNext      = '0;
        end
      end
      XFER: begin
        if (w_release) begin
          w_stateNext   = IDLE;
          w_grantNext   = '0;
          w_grantIdNext = '0;
          w_countNext   = '0;
        end else if (w_beat) begin
          w_countNext = w_countInc;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Everything is forced low while rst is high so a beat in the reset cycle is never written.
  always_comb begin
    bus.req_ready_o = '0;
    bus.fifo_wr_o   = 1'b0;
    bus.fifo_data_o = '0;
    bus.grant_o     = '0;
    bus.grant_id_o  = '0;
    bus.busy_o      = 1'b0;
    if (!rst) begin
      bus.grant_o    = r_grant;
      bus.grant_id_o = r_grantId;
      bus.busy_o     = (r_state == XFER);
      bus.fifo_wr_o  = w_beat;
      if (r_state == XFER) begin
        bus.fifo_data_o = w_grantData;
        if (!bus.fifo_full_i) bus.req_ready_o = r_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grantId    <= '0;
      r_lastWinner <= IDW'(NREQ - 1);
      r_count      <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_grant      <= w_grantNext;
      r_grantId    <= w_grantIdNext;
      r_lastWinner <= w_lastWinnerNext;
      r_count      <= w_countNext;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized plus directed bench for fifo_wr_arb, with a transaction-level arbiter model
// and a queue standing in for the downstream FWFT fifo (DEPTH 8).
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  localparam int NREQ     = 4;
  localparam int DWIDTH   = 8;
  localparam int MAXBURST = 4;
  localparam int DEPTH    = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAXBURST(MAXBURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t      srcQ [NREQ][$];
  bit         srcOn [NREQ];
  logic [7:0] fifoQ [$];
  logic [7:0] expQ [$];
  int         grantLog [$];
  logic [NREQ-1:0] prevGrant = '0;

  int  testsRun = 0, testsFailed = 0;
  int  popPct = 0;
  bit  forcePop = 0;
  int  wrSeen = 0, firstWr = -1, cycleNo = 0;
  logic [7:0] lastWrData = '0;

  // Arbiter model: owner index while granted, plus the number of beats taken so far.
  bit mBusy = 0;
  int mOwner = 0, mPtr = NREQ - 1, mCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushPacket(input int k, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) srcQ[k].push_back(beat_t'{data: 8'(base + 8'(i)), last: (i == len - 1)});
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance fifo, sources and model.
  task automatic applyStimulus();
    logic [NREQ-1:0] v, expGrant, expReady;
    logic [7:0]      drv [NREQ];
    logic [7:0]      expData, obsData, popped;
    logic            expWr, expBusy, lastBeat, doPop, obsWr, full;
    int              expId;
    for (int k = 0; k < NREQ; k++) begin
      v[k]   = srcOn[k] && (srcQ[k].size() > 0);
      drv[k] = (srcQ[k].size() > 0) ? srcQ[k][0].data : 8'($urandom);
      bus.req_valid_i[k] = v[k];
      bus.req_last_i[k]  = (srcQ[k].size() > 0) ? srcQ[k][0].last : 1'b0;
      bus.req_data_i[k*DWIDTH +: DWIDTH] = drv[k];
    end
    full = (fifoQ.size() >= DEPTH);
    bus.fifo_full_i = full;
    doPop = (fifoQ.size() > 0) && (forcePop || ($urandom_range(99) < popPct));
    forcePop = 0;
    #3;
    expGrant = '0; expReady = '0; expWr = 0; expBusy = 0; expData = '0; expId = 0; lastBeat = 0;
    if (!rst && mBusy) begin
      expBusy = 1;
      expId = mOwner;
      expGrant[mOwner] = 1'b1;
      expReady = full ? '0 : expGrant;
      expWr = v[mOwner] && !full;
      expData = drv[mOwner];
      lastBeat = (srcQ[mOwner].size() > 0) && srcQ[mOwner][0].last;
    end
    checkOutput("grant",   32'(bus.grant_o),     32'(expGrant));
    checkOutput("grantId", 32'(bus.grant_id_o),  expId);
    checkOutput("busy",    32'(bus.busy_o),      32'(expBusy));
    checkOutput("ready",   32'(bus.req_ready_o), 32'(expReady));
    checkOutput("wr",      32'(bus.fifo_wr_o),   32'(expWr));
    checkOutput("data",    32'(bus.fifo_data_o), 32'(expData));
    obsWr = bus.fifo_wr_o;
    obsData = bus.fifo_data_o;
    if (bus.grant_o != '0 && prevGrant == '0) grantLog.push_back(int'(bus.grant_id_o));
    prevGrant = bus.grant_o;
    @(posedge clk);
    if (doPop) begin
      popped = fifoQ.pop_front();
      if (expQ.size() > 0) checkOutput("drainOrder", 32'(popped), 32'(expQ.pop_front()));
    end
    if (obsWr) begin
      fifoQ.push_back(obsData);
      wrSeen++;
      if (firstWr < 0) firstWr = cycleNo;
      lastWrData = obsData;
    end
    if (expWr) begin
      expQ.push_back(expData);
      void'(srcQ[mOwner].pop_front());
    end
    if (rst) begin
      mBusy = 0; mPtr = NREQ - 1; mCount = 0;
    end else if (!mBusy) begin
      for (int s = 1; s <= NREQ; s++) begin
        int c = (mPtr + s) % NREQ;
        if (v[c]) begin
          mOwner = c; mPtr = c; mBusy = 1; mCount = 0;
          break;
        end
      end
    end else if (expWr) begin
      mCount++;
      if (lastBeat || mCount == MAXBURST) mBusy = 0;
    end
    cycleNo++;
    #1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic doReset();
    for (int k = 0; k < NREQ; k++) begin
      srcQ[k].delete();
      srcOn[k] = 0;
    end
    rst = 1;
    runCycles(2);
    rst = 0;
    fifoQ.delete();
    expQ.delete();
    grantLog.delete();
    wrSeen = 0;
    firstWr = -1;
    checkOutput("rstGrant",   32'(bus.grant_o),    0);
    checkOutput("rstGrantId", 32'(bus.grant_id_o), 0);
    checkOutput("rstBusy",    32'(bus.busy_o),     0);
  endtask

  task automatic checkLog(input string tag, input int idx, input int expected);
    checkOutput($sformatf("%s[%0d]", tag, idx), (idx < grantLog.size()) ? grantLog[idx] : -1, expected);
  endtask

  initial begin
    int startCycle, w0;
    int rrOrder [5] = '{0, 1, 2, 3, 0};

    // Single packet: first write lands in the second cycle of valid (IDLE sample, then XFER).
    doReset();
    popPct = 100;
    pushPacket(0, 3, 8'hA0);
    srcOn[0] = 1;
    startCycle = cycleNo;
    runCycles(8);
    checkOutput("singleWrCount", wrSeen, 3);
    checkOutput("firstWrOffset", firstWr - startCycle, 1);
    checkOutput("singleGrantOff", 32'(bus.grant_o), 0);

    // Round robin with 1-beat packets on every requester.
    doReset();
    for (int k = 0; k < NREQ; k++) begin
      pushPacket(k, 1, 8'(8'h10 * (k + 1)));
      pushPacket(k, 1, 8'(8'h10 * (k + 1) + 1));
      srcOn[k] = 1;
    end
    runCycles(20);
    for (int i = 0; i < 5; i++) checkLog("rrOrder", i, rrOrder[i]);

    // MAXBURST forces release after 4 beats of req1; req2 gets in, then req1 resumes.
    doReset();
    pushPacket(1, 6, 8'hB0);
    pushPacket(2, 1, 8'h2A);
    srcOn[1] = 1;
    srcOn[2] = 1;
    runCycles(16);
    checkLog("burstOrder", 0, 1);
    checkLog("burstOrder", 1, 2);
    checkLog("burstOrder", 2, 1);

    // Full backpressure: fill the fifo from req0, then one read lets exactly 0xC0 in.
    doReset();
    popPct = 0;
    pushPacket(0, 4, 8'h80);
    pushPacket(0, 4, 8'h84);
    pushPacket(0, 1, 8'hC0);
    srcOn[0] = 1;
    runCycles(20);
    wrSeen = 0;
    runCycles(8);
    checkOutput("fullNoWr", wrSeen, 0);
    checkOutput("fullLevel", fifoQ.size(), DEPTH);
    forcePop = 1;
    runCycles(6);
    checkOutput("afterReadWr", wrSeen, 1);
    checkOutput("afterReadData", 32'(lastWrData), 32'hC0);
    checkOutput("afterReadLevel", fifoQ.size(), DEPTH);
    popPct = 100;
    runCycles(12);

    // Stall: granted req3 drops valid mid-packet while req0 waits.
    doReset();
    pushPacket(3, 3, 8'hD0);
    pushPacket(0, 1, 8'hE0);
    srcOn[3] = 1;
    runCycles(2);
    srcOn[3] = 0;
    srcOn[0] = 1;
    wrSeen = 0;
    runCycles(5);
    checkOutput("stallNoWr", wrSeen, 0);
    checkOutput("stallGrantId", 32'(bus.grant_id_o), 3);
    srcOn[3] = 1;
    runCycles(10);
    checkLog("stallOrder", 0, 3);
    checkLog("stallOrder", 1, 0);

    // Reset during req2's second beat; afterwards req0 must win over req3 (pointer back at NREQ-1).
    doReset();
    pushPacket(2, 3, 8'hF0);
    srcOn[2] = 1;
    runCycles(2);
    rst = 1;
    w0 = wrSeen;
    runCycles(1);
    rst = 0;
    checkOutput("rstCycleWr", wrSeen - w0, 0);
    checkOutput("idleAfterRst", 32'(bus.busy_o), 0);
    pushPacket(0, 1, 8'h60);
    pushPacket(3, 1, 8'h63);
    srcOn[0] = 1;
    srcOn[3] = 1;
    runCycles(14);
    checkLog("rstOrder", 0, 2);
    checkLog("rstOrder", 1, 0);

    // Random traffic with random valid gaps, fifo reads and occasional resets.
    doReset();
    popPct = 40;
    repeat (1500) begin
      for (int k = 0; k < NREQ; k++) begin
        if (srcQ[k].size() == 0 && $urandom_range(3) == 0)
          pushPacket(k, int'($urandom_range(1, 6)), 8'($urandom));
        srcOn[k] = ($urandom_range(99) < 75);
      end
      rst = ($urandom_range(299) == 0);
      applyStimulus();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
